// File: rtl/t09_pkg.sv
// Shared types and constants for the obstacle placer.
// Playfield limits, coordinate type, placer states and distance helpers.
package t09_pkg;

    localparam int COORD_W = 4;

    typedef logic [COORD_W-1:0] coord_t;

    localparam coord_t X_MIN = 4'd1;
    localparam coord_t X_MAX = 4'd14;
    localparam coord_t Y_MIN = 4'd1;
    localparam coord_t Y_MAX = 4'd10;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        REROLL,
        DONE
    } placer_state_t;

    function automatic logic [4:0] absdiff(coord_t a, coord_t b);
        return (a >= b) ? ({1'b0, a} - {1'b0, b})
                        : ({1'b0, b} - {1'b0, a});
    endfunction

    function automatic logic [4:0] cheb(coord_t x, coord_t y,
                                       coord_t hx, coord_t hy);
        logic [4:0] dx;
        logic [4:0] dy;
        dx = absdiff(x, hx);
        dy = absdiff(y, hy);
        return (dx > dy) ? dx : dy;
    endfunction

    function automatic logic in_field(coord_t x, coord_t y);
        return (x >= X_MIN) && (x <= X_MAX) &&
               (y >= Y_MIN) && (y <= Y_MAX);
    endfunction

endpackage

// File: rtl/t09_obstacle_placer_if.sv
// Request/acknowledge bundle between game control and the placer.
// Control drives place_req/clear; the placer reports busy and completion.
interface t09_obstacle_placer_if;

    logic place_req;
    logic clear;
    logic busy;
    logic place_done;
    logic place_fail;

    modport master (
        output place_req,
        output clear,
        input  busy,
        input  place_done,
        input  place_fail
    );

    modport slave (
        input  place_req,
        input  clear,
        output busy,
        output place_done,
        output place_fail
    );

endinterface

// File: rtl/t09_obstacle_match.sv
// Combinational membership test of one cell against the used slots.
// Slots at or above count are ignored even if they hold stale data.
module t09_obstacle_match
    import t09_pkg::*;
#(
    parameter int N = 8
) (
    input  coord_t             x,
    input  coord_t             y,
    input  logic [4*N-1:0]     list_x,
    input  logic [4*N-1:0]     list_y,
    input  logic [3:0]         count,
    output logic               match
);

    // Scan every slot below count for an exact (x,y) hit.
    always_comb begin
        match = 1'b0;
        for (int i = 0; i < N; i++) begin
            if ((i < int'(count)) &&
                (list_x[COORD_W*i +: COORD_W] == x) &&
                (list_y[COORD_W*i +: COORD_W] == y)) begin
                match = 1'b1;
            end
        end
    end

endmodule

// File: rtl/t09_obstacle_placer.sv
// Obstacle placer: vets generator candidates and stores accepted cells.
// Rerolls the generator through obstacleFlag until success or give-up.
module t09_obstacle_placer
    import t09_pkg::*;
#(
    parameter int MAX_OBS   = 8,
    parameter int KEEP_OUT  = 2,
    parameter int MAX_TRIES = 15
) (
    input  logic                   clk,
    input  logic                   nRst,
    t09_obstacle_placer_if.slave   ctl,
    input  coord_t                 randX,
    input  coord_t                 randY,
    input  coord_t                 randX2,
    input  coord_t                 randY2,
    input  coord_t                 headX,
    input  coord_t                 headY,
    input  coord_t                 appleX,
    input  coord_t                 appleY,
    input  coord_t                 qX,
    input  coord_t                 qY,
    output logic                   obstacleFlag,
    output logic [3:0]             obs_count,
    output logic [4*MAX_OBS-1:0]   obs_x,
    output logic [4*MAX_OBS-1:0]   obs_y,
    output logic                   hit
);

    localparam logic [3:0] OBS_LIM = 4'(MAX_OBS);
    localparam logic [3:0] TRY_LIM = 4'(MAX_TRIES);
    localparam logic [4:0] KO      = 5'(KEEP_OUT);

    placer_state_t state;
    placer_state_t state_n;
    logic [3:0]    tries;
    logic [3:0]    tries_n;
    logic          fail_q;
    logic          fail_n;
    logic          wr_en;
    coord_t        wr_x;
    coord_t        wr_y;
    logic          match_a;
    logic          match_b;
    logic          legal_a;
    logic          legal_b;

    t09_obstacle_match #(.N(MAX_OBS)) u_match_a (
        .x(randX), .y(randY),
        .list_x(obs_x), .list_y(obs_y),
        .count(obs_count), .match(match_a)
    );

    t09_obstacle_match #(.N(MAX_OBS)) u_match_b (
        .x(randX2), .y(randY2),
        .list_x(obs_x), .list_y(obs_y),
        .count(obs_count), .match(match_b)
    );

    t09_obstacle_match #(.N(MAX_OBS)) u_match_q (
        .x(qX), .y(qY),
        .list_x(obs_x), .list_y(obs_y),
        .count(obs_count), .match(hit)
    );

    assign legal_a = in_field(randX, randY) && !match_a &&
                     !((randX == appleX) && (randY == appleY)) &&
                     (cheb(randX, randY, headX, headY) > KO);

    assign legal_b = in_field(randX2, randY2) && !match_b &&
                     !((randX2 == appleX) && (randY2 == appleY)) &&
                     (cheb(randX2, randY2, headX, headY) > KO);

    assign obstacleFlag   = (state == REROLL);
    assign ctl.busy       = (state != IDLE);
    assign ctl.place_done = (state == DONE);
    assign ctl.place_fail = (state == DONE) && fail_q;

    // Next state, retry bookkeeping and slot write select; clear overrides all.
    always_comb begin
        state_n = state;
        tries_n = tries;
        fail_n  = fail_q;
        wr_en   = 1'b0;
        wr_x    = randX;
        wr_y    = randY;
        unique case (state)
            IDLE: begin
                tries_n = '0;
                if (ctl.place_req) begin
                    if (obs_count < OBS_LIM) begin
                        state_n = CHECK;
                    end else begin
                        fail_n  = 1'b1;
                        state_n = DONE;
                    end
                end
            end
            CHECK: begin
                if (legal_a) begin
                    wr_en   = 1'b1;
                    fail_n  = 1'b0;
                    state_n = DONE;
                end else if (legal_b) begin
                    wr_en   = 1'b1;
                    wr_x    = randX2;
                    wr_y    = randY2;
                    fail_n  = 1'b0;
                    state_n = DONE;
                end else begin
                    tries_n = tries + 4'd1;
                    if (tries_n == TRY_LIM) begin
                        fail_n  = 1'b1;
                        state_n = DONE;
                    end else begin
                        state_n = REROLL;
                    end
                end
            end
            REROLL: state_n = CHECK;
            DONE: begin
                tries_n = '0;
                state_n = IDLE;
            end
        endcase
        if (ctl.clear) begin
            state_n = IDLE;
            tries_n = '0;
            fail_n  = 1'b0;
            wr_en   = 1'b0;
        end
    end

    // State, retry counter and obstacle list registers.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state     <= IDLE;
            tries     <= '0;
            fail_q    <= 1'b0;
            obs_count <= '0;
            obs_x     <= '0;
            obs_y     <= '0;
        end else begin
            state  <= state_n;
            tries  <= tries_n;
            fail_q <= fail_n;
            if (ctl.clear) begin
                obs_count <= '0;
                obs_x     <= '0;
                obs_y     <= '0;
            end else if (wr_en) begin
                obs_count <= obs_count + 4'd1;
                for (int i = 0; i < MAX_OBS; i++) begin
                    if (i == int'(obs_count)) begin
                        obs_x[COORD_W*i +: COORD_W] <= wr_x;
                        obs_y[COORD_W*i +: COORD_W] <= wr_y;
                    end
                end
            end
        end
    end

endmodule
